// File: rtl/mips_pkg.sv
// Shared constants and state type for the register file, its clear sequencer and its users.
package mips_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int REG_ZERO    = 0;
  localparam int REG_SPECIAL = 30;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every storage entry once, writing zero, then holds RUN.
//  state | meaning
//  CLEAR | storage being zeroed, ports not live
//  RUN   | clear finished, ready held high until the next reset
module regfile_clear_seq #(
  parameter int ADDR_W    = mips_pkg::ADDR_W,
  parameter int SPEC_ADDR = mips_pkg::REG_SPECIAL
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] SPEC      = ADDR_W'(SPEC_ADDR);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= ADDR_W'(1);
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_ptr == LAST_ADDR) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= CLEAR;
      endcase
    end
  end

  // The special register has no storage behind it, so its slot is skipped.
  assign clr_we   = (r_state == CLEAR) && (r_clr_ptr != SPEC);
  assign clr_addr = r_clr_ptr;
  assign ready    = r_ready;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-back bypass, hardwired zero, special register
// and a per-register busy scoreboard that stalls WAW issues.
module regfile_scoreboard #(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int ADDR_W    = mips_pkg::ADDR_W,
  parameter int NREAD     = 2,
  parameter int SPEC_ADDR = mips_pkg::REG_SPECIAL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic                    iss_stall,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic [DATA_W-1:0]       sp_in,
  output logic [DATA_W-1:0]       sp_out
);
  import mips_pkg::*;

  localparam int                NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] SPEC  = ADDR_W'(SPEC_ADDR);

  logic [DATA_W-1:0] r_mem [1:NREGS-1];
  logic [NREGS-1:0]  r_busy;
  logic [NREGS-1:0]  w_busy_nxt;
  logic [DATA_W-1:0] r_sp_out;

  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wb_live;
  logic              w_iss_set;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  regfile_clear_seq #(
    .ADDR_W    (ADDR_W),
    .SPEC_ADDR (SPEC_ADDR)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (w_ready),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign ready     = w_ready;
  assign w_wb_live = w_ready && wb_en && (wb_addr != ZERO);

  // A write-back retiring the same register this cycle frees the slot for the new producer.
  assign iss_stall = !w_ready ||
                     (iss_valid && (iss_addr != ZERO) && r_busy[iss_addr] &&
                      !(wb_en && (wb_addr == iss_addr)));
  assign w_iss_set = w_ready && iss_valid && !iss_stall && (iss_addr != ZERO);

  // Single storage write port shared between the clear sequencer and write-back.
  assign w_we    = w_ready ? (w_wb_live && (wb_addr != SPEC)) : w_clr_we;
  assign w_waddr = w_ready ? wb_addr : w_clr_addr;
  assign w_wdata = w_ready ? wb_data : '0;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_live) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    // Issue set is applied last so it wins over a same-cycle write-back clear.
    if (w_iss_set) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_sp_out <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_wb_live && (wb_addr == SPEC)) begin
        r_sp_out <= wb_data;
      end
    end
  end

  assign sp_out = r_sp_out;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = '0;
      w_bsy  = 1'b0;
      if (w_a == ZERO) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end else if (w_a == SPEC) begin
        w_data = sp_in;
        w_bsy  = r_busy[w_a];
      end else if (w_ready && wb_en && (wb_addr == w_a)) begin
        w_data = wb_data;
        w_bsy  = 1'b0;
      end else begin
        w_data = r_mem[w_a];
        w_bsy  = r_busy[w_a];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_data;
    assign rd_busy[k]                  = w_bsy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: array/counter reference model compared
// every negedge, plus directed scenarios with literal expectations.
module tb_regfile_scoreboard;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int NR       = 2;
  localparam int SPECA    = 30;
  localparam int CLR_CYCS = 31;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ready;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             iss_valid;
  logic [AW-1:0]    iss_addr;
  logic             iss_stall;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic [DW-1:0]    sp_in;
  logic [DW-1:0]    sp_out;

  int n_cmp = 0;
  int n_err = 0;

  regfile_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .SPEC_ADDR(SPECA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .sp_in(sp_in), .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents, pending-write flags, special output, clear counter.
  logic [DW-1:0] m_mem [32];
  logic [31:0]   m_busy;
  logic [DW-1:0] m_sp;
  logic          m_ready;
  int            m_cnt;
  logic          m_valid = 1'b0;

  function automatic logic exp_stall();
    if (!m_ready) return 1'b1;
    return iss_valid && (iss_addr != 0) && m_busy[iss_addr] && !(wb_en && wb_addr == iss_addr);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (a == AW'(SPECA)) return sp_in;
    if (wb_en && wb_addr == a) return wb_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (a == AW'(SPECA)) return m_busy[a];
    if (wb_en && wb_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_cnt   <= 0;
      m_ready <= 1'b0;
      m_busy  <= '0;
      m_sp    <= '0;
    end else if (!m_ready) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == CLR_CYCS - 1) begin
        m_ready <= 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] <= '0;
      end
    end else begin
      if (wb_en && wb_addr != 0) begin
        if (wb_addr == AW'(SPECA)) m_sp <= wb_data;
        else m_mem[wb_addr] <= wb_data;
        m_busy[wb_addr] <= 1'b0;
      end
      if (iss_valid && iss_addr != 0 && !exp_stall()) m_busy[iss_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", 32'(ready), 32'(m_ready));
      check("sp_out", sp_out, m_sp);
      check("iss_stall", 32'(iss_stall), 32'(exp_stall()));
      if (m_ready) begin
        for (int k = 0; k < NR; k++) begin
          check("rd_data", rd_data[k*DW +: DW], exp_rd(rd_addr[k*AW +: AW]));
          check("rd_busy", 32'(rd_busy[k]), 32'(exp_rb(rd_addr[k*AW +: AW])));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      if (cyc == 10) check("stall_in_clear", 32'(iss_stall), 32'd1);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    wb_en     = 1'b0;
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0; rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; sp_in = '0;
    repeat (3) step();
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_sp_out", sp_out, 32'd0);
    step();
    rst_n = 1'b1;

    wait_ready(cyc);
    check("clear_cycles", 32'(cyc), 32'd31);

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'd0, 5'(a)};
      @(negedge clk);
      check("cleared_reg", rd_data[31:0], 32'd0);
      check("cleared_busy", 32'(rd_busy[0]), 32'd0);
      step();
    end

    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    check("bypass", rd_data[31:0], 32'hDEADBEEF);
    step();
    wb_en = 1'b0;
    @(negedge clk);
    check("stored", rd_data[31:0], 32'hDEADBEEF);
    step();

    iss_valid = 1'b1; iss_addr = 5'd7; rd_addr = {5'd7, 5'd0};
    @(negedge clk);
    check("issue1_stall", 32'(iss_stall), 32'd0);
    step();
    @(negedge clk);
    check("issue2_stall", 32'(iss_stall), 32'd1);
    check("busy7", 32'(rd_busy[1]), 32'd1);
    step();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    @(negedge clk);
    check("issue_wb_stall", 32'(iss_stall), 32'd0);
    step();
    idle();
    @(negedge clk);
    check("busy7_after", 32'(rd_busy[1]), 32'd1);
    check("data7_after", rd_data[63:32], 32'h77);
    step();

    wb_en = 1'b1; wb_addr = 5'd30; wb_data = 32'h1234; sp_in = 32'hAA; rd_addr = {5'd0, 5'd30};
    @(negedge clk);
    check("rd_special", rd_data[31:0], 32'hAA);
    step();
    wb_en = 1'b0;
    @(negedge clk);
    check("sp_out_upd", sp_out, 32'h1234);
    step();

    for (int i = 0; i < 40; i++) begin
      wb_en     = (i % 3) != 0;
      wb_addr   = 5'((i * 7) % 32);
      wb_data   = 32'h1000_0000 + 32'(i) * 32'h111;
      iss_valid = (i % 2) == 1;
      iss_addr  = 5'((i * 5 + 3) % 32);
      sp_in     = 32'h5500 + 32'(i);
      rd_addr   = {5'((i * 11) % 32), 5'((i * 7) % 32)};
      step();
    end
    idle();
    step();

    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33; iss_valid = 1'b1; iss_addr = 5'd3;
    rd_addr = {5'd0, 5'd3};
    step();
    idle();
    @(negedge clk);
    check("set_wins_busy", 32'(rd_busy[0]), 32'd1);
    check("set_wins_data", rd_data[31:0], 32'h33);
    step();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    check("midrun_reset_ready", 32'(ready), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (12) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_ready(cyc);
    check("reclear_cycles", 32'(cyc), 32'd31);
    @(negedge clk);
    check("reg3_cleared", rd_data[31:0], 32'd0);
    check("busy3_cleared", 32'(rd_busy[0]), 32'd0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
